sprite_jump_physics: RTL
========================

Name: sprite_jump_physics

Overview:
Parameterised successor of the single-sprite jump controller. Owns one sprite's X/Y position, driven by button inputs under a variable-period gravity model. Adds horizontal motion with clamping, a ground/landing state, a direction flip bit and a configurable sprite-table slot. Emits the 32-bit sprite descriptor word and slot address consumed by the sprite renderer.

Parameters:
X_W, 10, position width (both axes)
T_W, 20, jump timer/period width
START_X, 80, reset X
START_Y, 64, reset Y
MIN_X, 0, left clamp
MAX_X, 608, right clamp
MIN_Y, 32, ceiling clamp
MAX_Y, 448, ground Y
T_START, 100000, initial rise period (cycles)
T_STEP, 10000, period increment/decrement per move
T_MAX, 800000, rise-to-fall threshold; first fall period
T_TERM, 250000, terminal fall period
FRAME_SPLIT, 550000, animation frame threshold
H_PERIOD, 200000, cycles per 1-pixel horizontal step
SLOT, 0, sprite table address
TAG, 5'b10000, descriptor tag bits

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
up  in  1  jump button, synchronous to clk
down  in  1  fast-fall button (used only with FAST_FALL_EN)
left  in  1  move left
right  in  1  move right
game_over  in  1  freeze motion, show dead frame
pos_x  out  X_W  current X
pos_y  out  X_W  current Y
dina  out  32  {TAG[4:0], flip, pos_x, pos_y, rom_row[2:0], rom_col[2:0]}; X_W=10 only
addr  out  3  SLOT constant

Behaviour:
- Reset (async): pos_x=START_X, pos_y=START_Y, state=FALL, period=T_START, timer=T_START, flip=0, hcnt=0, up_prev=0.
- up_edge = up & ~up_prev; up_prev registered every cycle. Outside game_over, up_edge forces RISE, period=T_START, timer=T_START, in any state; overrides the same-cycle tick. Held button produces one edge.
- Tick: timer==0. Non-tick cycles: timer decrements. Move interval is therefore period+1 cycles.
- RISE tick: pos_y-=1 if pos_y>MIN_Y, else holds. If period<=T_MAX: period+=T_STEP, timer=new period. Else: state=FALL, period=T_MAX, timer=T_MAX (the decrement still applies on that tick).
- FALL tick: if pos_y<MAX_Y, pos_y+=1. If period>T_TERM: period-=T_STEP, timer=new period; else timer=T_TERM. If the new pos_y equals MAX_Y, state=GROUND.
- GROUND: no vertical motion, timer idle; leaves only on up_edge.
- Horizontal: hcnt counts to H_PERIOD-1 then wraps to 0. On wrap, exactly one of left/right held moves x by 1, clamped to [MIN_X,MAX_X]. Both or neither held: no move. left sets flip=1, right sets flip=0, at step time only.
- game_over=1: all position, state and timer registers hold; up_edge ignored; up_prev still tracks.
- Frame (combinational from next-state values):
  - game_over: row=1, col=0.
  - RISE: row=(period<FRAME_SPLIT), col=1.
  - FALL: row=col=(period>FRAME_SPLIT).
  - GROUND: row=0, col=0.
- All comparisons unsigned; period arithmetic T_W bits, no wrap for legal parameters.

Optional Feature:
FAST_FALL_EN. Defined: down held in FALL on any cycle forces period=T_TERM; timer=min(timer,T_TERM); RISE ignores down. Undefined: the down port is unused and has no effect.

Test Plan:
- Reset mid-rise: assert reset asynchronously between clock edges -> pos_x=80, pos_y=64, state FALL, flip=0 immediately, before the next clock edge.
- Rise profile with T_START=4, T_STEP=2, T_MAX=12, T_TERM=6, pos_y=64: single up edge -> decrements at intervals of 5, 7, 9, 11, 13, 15 cycles; pos_y=58; state FALL with period 12.
- Fall to ground, same params: from FALL with period 12 -> intervals 13, 11, 9, 7, 7, 7...; reaches MAX_Y and enters GROUND; pos_y holds; frame row=0, col=0.
- Re-jump and held button: up edge mid-fall -> RISE, period=T_START on the next cycle. Holding up for 100 cycles -> exactly one restart.
- Horizontal clamp, H_PERIOD=4, MIN_X=0, pos_x=1: hold left 12 cycles -> pos_x=0, flip=1, stays 0. left+right together -> no move.
- game_over freeze: assert during RISE -> pos_x/pos_y constant, dina row=1, col=0, up edges ignored. Deassert -> motion resumes from the frozen timer value.

Source files
------------

// File: rtl/sprite_jump_physics.sv
// One sprite's position under a variable-period jump/gravity model plus clamped horizontal motion.
// Optional FAST_FALL_EN: holding down while falling jumps straight to the terminal fall period.
module sprite_jump_physics #(
  parameter int         X_W         = 10,
  parameter int         T_W         = 20,
  parameter int         START_X     = 80,
  parameter int         START_Y     = 64,
  parameter int         MIN_X       = 0,
  parameter int         MAX_X       = 608,
  parameter int         MIN_Y       = 32,
  parameter int         MAX_Y       = 448,
  parameter int         T_START     = 100000,
  parameter int         T_STEP      = 10000,
  parameter int         T_MAX       = 800000,
  parameter int         T_TERM      = 250000,
  parameter int         FRAME_SPLIT = 550000,
  parameter int         H_PERIOD    = 200000,
  parameter int         SLOT        = 0,
  parameter logic [4:0] TAG         = 5'b10000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           game_over,
  output logic [X_W-1:0] pos_x,
  output logic [X_W-1:0] pos_y,
  output logic [31:0]    dina,
  output logic [2:0]     addr
);

  localparam logic [X_W-1:0] START_X_V = X_W'(START_X);
  localparam logic [X_W-1:0] START_Y_V = X_W'(START_Y);
  localparam logic [X_W-1:0] MIN_X_V   = X_W'(MIN_X);
  localparam logic [X_W-1:0] MAX_X_V   = X_W'(MAX_X);
  localparam logic [X_W-1:0] MIN_Y_V   = X_W'(MIN_Y);
  localparam logic [X_W-1:0] MAX_Y_V   = X_W'(MAX_Y);
  localparam logic [T_W-1:0] T_START_V = T_W'(T_START);
  localparam logic [T_W-1:0] T_STEP_V  = T_W'(T_STEP);
  localparam logic [T_W-1:0] T_MAX_V   = T_W'(T_MAX);
  localparam logic [T_W-1:0] T_TERM_V  = T_W'(T_TERM);
  localparam logic [T_W-1:0] SPLIT_V   = T_W'(FRAME_SPLIT);
  localparam logic [T_W-1:0] H_LAST_V  = T_W'(H_PERIOD - 1);

  typedef enum logic [1:0] {ST_RISE, ST_FALL, ST_GROUND} state_t;

  state_t         state_q, state_d;
  logic [T_W-1:0] period_q, period_d;
  logic [T_W-1:0] timer_q, timer_d;
  logic [T_W-1:0] hcnt_q, hcnt_d;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [X_W-1:0] pos_y_q, pos_y_d;
  logic           flip_q, flip_d;
  logic           up_prev_q;
  logic           up_edge;
  logic           tick;
  logic [2:0]     row, col;

`ifndef FAST_FALL_EN
  logic unused_down;
  assign unused_down = down;
`endif

  assign up_edge = up & ~up_prev_q;
  assign tick    = (timer_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FALL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q  <= T_START_V;
      timer_q   <= T_START_V;
      hcnt_q    <= '0;
      pos_x_q   <= START_X_V;
      pos_y_q   <= START_Y_V;
      flip_q    <= 1'b0;
      up_prev_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      timer_q   <= timer_d;
      hcnt_q    <= hcnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      flip_q    <= flip_d;
      up_prev_q <= up;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    timer_d  = timer_q;
    hcnt_d   = hcnt_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    flip_d   = flip_q;
    if (!game_over) begin
      // A fresh press restarts the jump from any state and pre-empts this cycle's tick.
      if (up_edge) begin
        state_d  = ST_RISE;
        period_d = T_START_V;
        timer_d  = T_START_V;
      end else begin
        case (state_q)
          ST_RISE: begin
            if (tick) begin
              if (pos_y_q > MIN_Y_V) pos_y_d = pos_y_q - 1'b1;
              if (period_q <= T_MAX_V) begin
                period_d = period_q + T_STEP_V;
                timer_d  = period_q + T_STEP_V;
              end else begin
                state_d  = ST_FALL;
                period_d = T_MAX_V;
                timer_d  = T_MAX_V;
              end
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
          ST_FALL: begin
            if (tick) begin
              if (pos_y_q < MAX_Y_V) pos_y_d = pos_y_q + 1'b1;
              if (period_q > T_TERM_V) begin
                period_d = period_q - T_STEP_V;
                timer_d  = period_q - T_STEP_V;
              end else begin
                timer_d = T_TERM_V;
              end
              if (pos_y_d == MAX_Y_V) state_d = ST_GROUND;
            end else begin
              timer_d = timer_q - 1'b1;
            end
`ifdef FAST_FALL_EN
            if (down) begin
              period_d = T_TERM_V;
              if (timer_d > T_TERM_V) timer_d = T_TERM_V;
            end
`endif
          end
          default: begin
          end
        endcase
      end
      if (hcnt_q == H_LAST_V) begin
        hcnt_d = '0;
        if (left && !right) begin
          flip_d = 1'b1;
          if (pos_x_q > MIN_X_V) pos_x_d = pos_x_q - 1'b1;
        end else if (right && !left) begin
          flip_d = 1'b0;
          if (pos_x_q < MAX_X_V) pos_x_d = pos_x_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Animation frame follows the state being entered, so it never lags a transition.
  always_comb begin
    row = 3'd0;
    col = 3'd0;
    if (game_over) begin
      row = 3'd1;
    end else begin
      case (state_d)
        ST_RISE: begin
          row = {2'b00, (period_d < SPLIT_V)};
          col = 3'd1;
        end
        ST_FALL: begin
          row = {2'b00, (period_d > SPLIT_V)};
          col = {2'b00, (period_d > SPLIT_V)};
        end
        default: begin
        end
      endcase
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign dina  = {TAG, flip_q, pos_x_q, pos_y_q, row, col};
  assign addr  = 3'(SLOT);

endmodule
